// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers; fixed-latency MULT/DIV, MTHI/MTLO, cancel on flush.
// Latency MULT_CYCLES/DIV_CYCLES busy cycles; busy is a pure function of state; start while busy is ignored.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // Result is computed combinationally from the latched operands and committed on the last busy cycle.
  logic               signed_op, a_neg, b_neg, div_by_zero;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    signed_op   = ~op_q[0];
    a_ext       = {{WIDTH{signed_op & a_q[WIDTH-1]}}, a_q};
    b_ext       = {{WIDTH{signed_op & b_q[WIDTH-1]}}, b_q};
    prod        = a_ext * b_ext;
    a_neg       = signed_op & a_q[WIDTH-1];
    b_neg       = signed_op & b_q[WIDTH-1];
    a_mag       = a_neg ? -a_q : a_q;
    b_mag       = b_neg ? -b_q : b_q;
    div_by_zero = (b_q == '0);
    q_mag       = div_by_zero ? '0 : a_mag / b_mag;
    r_mag       = div_by_zero ? '0 : a_mag % b_mag;
    // Magnitude division gives truncation toward zero; the most-negative/-1 case wraps naturally.
    quo         = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem         = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b;
              cnt_d   = op[1] ? DIV_LAT : MULT_LAT;
              state_d = S_RUN;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod;
          end else if (!div_by_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a 32-bit default instance and an 8-bit/1/3-cycle instance, checked every cycle
// against a transaction-level arithmetic model, plus hand-computed literal expectations.
module tb_md_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_i[2];
  logic [2:0]  op_i[2];
  logic [31:0] a_i[2];
  logic [31:0] b_i[2];
  logic        cancel_i[2];
  logic        busy_o[2];
  logic        done_o[2];
  logic [31:0] hi_o[2];
  logic [31:0] lo_o[2];
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  md_unit u0 (
    .clk(clk), .reset(rst_n), .start(start_i[0]), .op(op_i[0]), .a(a_i[0]), .b(b_i[0]),
    .cancel(cancel_i[0]), .busy(busy_o[0]), .done(done_o[0]), .hi(hi_o[0]), .lo(lo_o[0])
  );

  md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) u1 (
    .clk(clk), .reset(rst_n), .start(start_i[1]), .op(op_i[1]), .a(a_i[1][7:0]), .b(b_i[1][7:0]),
    .cancel(cancel_i[1]), .busy(busy_o[1]), .done(done_o[1]), .hi(hi8), .lo(lo8)
  );
  assign hi_o[1] = {24'd0, hi8};
  assign lo_o[1] = {24'd0, lo8};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wid(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic int lat(input int k, input logic [2:0] op);
    if (k == 0) return (op < 3'd2) ? 5 : 10;
    return (op < 3'd2) ? 1 : 3;
  endfunction

  // Reference arithmetic on 64-bit integers.
  function automatic void model_op(input int w, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] h,
                                   output logic [31:0] l, output bit wr);
    logic [63:0] mask, p;
    longint x, y, q, r;
    bit sgn;
    mask = (64'd1 << w) - 64'd1;
    sgn  = (op == 3'd0) || (op == 3'd2);
    x = longint'(a & mask[31:0]);
    y = longint'(b & mask[31:0]);
    if (sgn && a[w-1]) x = x - (longint'(1) << w);
    if (sgn && b[w-1]) y = y - (longint'(1) << w);
    wr = 1'b1;
    h  = '0;
    l  = '0;
    if (op < 3'd2) begin
      p = x * y;
      l = 32'(p & mask);
      h = 32'((p >> w) & mask);
    end else if (y == 0) begin
      wr = 1'b0;
    end else begin
      q = x / y;
      r = x % y;
      l = 32'(q & mask);
      h = 32'(r & mask);
    end
  endfunction

  int          m_left[2];
  logic [31:0] m_hi[2], m_lo[2], m_rhi[2], m_rlo[2];
  bit          m_wr[2], m_done[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_hi[k] = '0; m_lo[k] = '0; m_rhi[k] = '0; m_rlo[k] = '0;
      m_wr[k] = 1'b0; m_done[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    logic [31:0] th, tl, msk;
    bit tw;
    for (int k = 0; k < 2; k++) begin
      msk = (wid(k) == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      if (!rst_n) begin
        m_left[k] <= 0; m_hi[k] <= '0; m_lo[k] <= '0; m_done[k] <= 1'b0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_left[k] > 0) begin
          if (cancel_i[k]) begin
            m_left[k] <= 0;
          end else if (m_left[k] == 1) begin
            m_left[k] <= 0;
            m_done[k] <= 1'b1;
            if (m_wr[k]) begin
              m_hi[k] <= m_rhi[k];
              m_lo[k] <= m_rlo[k];
            end
          end else begin
            m_left[k] <= m_left[k] - 1;
          end
        end else if (start_i[k]) begin
          if (op_i[k] < 3'd4) begin
            model_op(wid(k), op_i[k], a_i[k], b_i[k], th, tl, tw);
            m_rhi[k]  <= th;
            m_rlo[k]  <= tl;
            m_wr[k]   <= tw;
            m_left[k] <= lat(k, op_i[k]);
          end else if (op_i[k] == 3'd4) begin
            m_hi[k] <= a_i[k] & msk;
          end else if (op_i[k] == 3'd5) begin
            m_lo[k] <= a_i[k] & msk;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), {31'd0, busy_o[k]}, {31'd0, (m_left[k] > 0)});
        chk($sformatf("done%0d", k), {31'd0, done_o[k]}, {31'd0, m_done[k]});
        chk($sformatf("hi%0d", k), hi_o[k], m_hi[k]);
        chk($sformatf("lo%0d", k), lo_o[k], m_lo[k]);
      end
    end
  end

  task automatic go(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i[k] = 1'b1; op_i[k] = op; a_i[k] = a; b_i[k] = b;
    @(negedge clk);
    start_i[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input string nm, input int exp_lat);
    int c = 0;
    while (busy_o[k] && c < 200) begin
      c++;
      @(negedge clk);
    end
    chk({nm, "_lat"}, c, exp_lat);
    chk({nm, "_done"}, {31'd0, done_o[k]}, 32'd1);
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h80;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; op_i[k] = '0; a_i[k] = '0; b_i[k] = '0; cancel_i[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_hi", hi_o[0], 32'h0);
    chk("rst_lo", lo_o[0], 32'h0);
    chk("rst_busy", {31'd0, busy_o[0]}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    go(0, 3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_idle(0, "mult", 5);
    chk("mult_hi", hi_o[0], 32'hFFFF_FFFF);
    chk("mult_lo", lo_o[0], 32'hFFFF_FFF1);
    go(0, 3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(0, "multu", 5);
    chk("multu_hi", hi_o[0], 32'h0000_0001);
    chk("multu_lo", lo_o[0], 32'hFFFF_FFFE);
    go(0, 3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(0, "div", 10);
    chk("div_lo", lo_o[0], 32'hFFFF_FFFD);
    chk("div_hi", hi_o[0], 32'hFFFF_FFFF);
    go(0, 3'd3, 32'd7, 32'd2);
    wait_idle(0, "divu", 10);
    chk("divu_lo", lo_o[0], 32'd3);
    chk("divu_hi", hi_o[0], 32'd1);
    go(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(0, "divovf", 10);
    chk("divovf_lo", lo_o[0], 32'h8000_0000);
    chk("divovf_hi", hi_o[0], 32'h0);

    go(0, 3'd4, 32'h1234, 32'd0);
    chk("mthi_hi", hi_o[0], 32'h1234);
    chk("mthi_busy", {31'd0, busy_o[0]}, 32'h0);
    go(0, 3'd5, 32'h5678, 32'd0);
    chk("mtlo_lo", lo_o[0], 32'h5678);
    go(0, 3'd2, 32'd9, 32'd0);
    wait_idle(0, "div0", 10);
    chk("div0_hi", hi_o[0], 32'h1234);
    chk("div0_lo", lo_o[0], 32'h5678);

    go(0, 3'd0, 32'd6, 32'd7);
    @(negedge clk);
    start_i[0] = 1'b1; op_i[0] = 3'd4; a_i[0] = 32'hAAAA;
    @(negedge clk);
    op_i[0] = 3'd2; a_i[0] = 32'd100; b_i[0] = 32'd3;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_idle(0, "ign", 2);
    chk("ign_hi", hi_o[0], 32'h0);
    chk("ign_lo", lo_o[0], 32'd42);

    go(0, 3'd0, 32'd3, 32'd3);
    repeat (2) @(negedge clk);
    cancel_i[0] = 1'b1;
    @(negedge clk);
    cancel_i[0] = 1'b0;
    chk("cancel_busy", {31'd0, busy_o[0]}, 32'h0);
    repeat (6) begin
      chk("cancel_nodone", {31'd0, done_o[0]}, 32'h0);
      @(negedge clk);
    end
    chk("cancel_hi", hi_o[0], 32'h0);
    chk("cancel_lo", lo_o[0], 32'd42);

    go(0, 3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstrun_busy", {31'd0, busy_o[0]}, 32'h0);
    chk("rstrun_hi", hi_o[0], 32'h0);
    chk("rstrun_lo", lo_o[0], 32'h0);
    repeat (12) begin
      chk("rstrun_nodone", {31'd0, done_o[0]}, 32'h0);
      @(negedge clk);
    end

    go(1, 3'd0, 32'h80, 32'h80);
    wait_idle(1, "m8", 1);
    chk("m8_hi", hi_o[1], 32'h40);
    chk("m8_lo", lo_o[1], 32'h00);
    go(1, 3'd3, 32'd200, 32'd7);
    wait_idle(1, "d8a", 3);
    chk("d8a_lo", lo_o[1], 32'd28);
    chk("d8a_hi", hi_o[1], 32'd4);
    go(1, 3'd3, 32'd100, 32'd9);
    wait_idle(1, "d8b", 3);
    chk("d8b_lo", lo_o[1], 32'd11);
    chk("d8b_hi", hi_o[1], 32'd1);

    repeat (3000) begin
      for (int k = 0; k < 2; k++) begin
        start_i[k]  = ($urandom_range(0, 2) == 0);
        op_i[k]     = 3'($urandom_range(0, 7));
        a_i[k]      = rnd();
        b_i[k]      = rnd();
        cancel_i[k] = ($urandom_range(0, 15) == 0);
      end
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0; cancel_i[k] = 1'b0;
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
